reg_select_scoreboard: RTL

- Parametrised successor to the register-select decoder of the register file.
- Decodes a binary register index into one-hot write enables, now registered.
- Adds a per-register busy scoreboard so issue logic stalls on an in-flight destination register.
- Sits between the control unit (issue side) and the register file (writeback side).

---
 rtl/reg_select_scoreboard_if.sv | 38 +++
 rtl/reg_select_scoreboard.sv | 116 +++++++++++
 2 files changed

// File: rtl/reg_select_scoreboard_if.sv
// reg_select_scoreboard_if
//   Issue/writeback bundle between the control unit, the busy scoreboard
//   and the register file.
//   master : issue/writeback requester (control unit side, or a bench)
//   slave  : reg_select_scoreboard
//   issue_valid/issue_reg  -> claim a destination register
//   issue_ready            <- claim accepted this cycle (combinational)
//   issue_sel              <- registered one-hot pulse of the accepted claim
//   wb_valid/wb_reg        -> writeback, never back-pressured
//   wr_en                  <- registered one-hot register-file write enable
//   busy/busy_count        <- scoreboard vector and its population count
//   err_wb_idle            <- sticky: writeback to a register that was not busy
interface reg_select_scoreboard_if #(
  parameter int ADDR_W = 3
);
  localparam int NREG = 2**ADDR_W;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_reg;
  logic              issue_ready;
  logic [NREG-1:0]   issue_sel;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_reg;
  logic [NREG-1:0]   wr_en;
  logic [NREG-1:0]   busy;
  logic [ADDR_W:0]   busy_count;
  logic              err_wb_idle;

  modport master (
    output issue_valid, issue_reg, wb_valid, wb_reg,
    input  issue_ready, issue_sel, wr_en, busy, busy_count, err_wb_idle
  );

  modport slave (
    input  issue_valid, issue_reg, wb_valid, wb_reg,
    output issue_ready, issue_sel, wr_en, busy, busy_count, err_wb_idle
  );
endinterface

// File: rtl/reg_select_scoreboard.sv
// reg_select_scoreboard
//   Decodes binary register indices into registered one-hot enables and
//   keeps a per-register busy scoreboard so issue stalls on a destination
//   register with a write still in flight.
//   clock : rising-edge clock
//   reset : synchronous, active-high; also forces issue_ready low
//   bus   : reg_select_scoreboard_if.slave (issue, writeback, status)
//   MSB_FIRST=1 maps register k to bit NREG-1-k of every vector output,
//   MSB_FIRST=0 maps register k to bit k.

// One scoreboard entry. Exposes its next-state value so the top can
// register a popcount that tracks the busy vector cycle for cycle.
module reg_select_slot (
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  logic clr,
  output logic q,
  output logic d
);
  // A same-cycle claim beats the writeback clear: the new write is in flight.
  assign d = set | (q & ~clr);

  always_ff @(posedge clock) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end
endmodule

module reg_select_scoreboard #(
  parameter int ADDR_W    = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  reg_select_scoreboard_if.slave bus
);
  localparam int NREG = 2**ADDR_W;

  // Vector bit position of a register index. NREG is a power of two, so
  // NREG-1-k is just the bitwise complement of k.
  function automatic logic [ADDR_W-1:0] bitpos(input logic [ADDR_W-1:0] idx);
    return MSB_FIRST ? ~idx : idx;
  endfunction

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
    return {{(NREG-1){1'b0}}, 1'b1} << bitpos(idx);
  endfunction

  function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + {{ADDR_W{1'b0}}, v[i]};
    return c;
  endfunction

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] issue_oh, wb_oh;
  logic [NREG-1:0] set_v, clr_v;
  logic            issue_ready;
  logic            issue_acc;
  logic            wb_hit_idle;

  logic [NREG-1:0] issue_sel_q, wr_en_q;
  logic [ADDR_W:0] busy_count_q;
  logic            err_q;

  assign issue_oh = onehot(bus.issue_reg);
  assign wb_oh    = onehot(bus.wb_reg);

  // A busy destination can still be claimed when its writeback lands in
  // the same cycle; the index compare is mapping independent.
  assign issue_ready = ~reset &
                       (~busy_q[bitpos(bus.issue_reg)] |
                        (bus.wb_valid & (bus.wb_reg == bus.issue_reg)));
  assign issue_acc   = bus.issue_valid & issue_ready;

  // Error looks at the pre-update busy bit, so a same-cycle claim of the
  // same register does not hide it.
  assign wb_hit_idle = bus.wb_valid & ~busy_q[bitpos(bus.wb_reg)];

  assign set_v = issue_acc    ? issue_oh : '0;
  assign clr_v = bus.wb_valid ? wb_oh    : '0;

  for (genvar g = 0; g < NREG; g++) begin : g_slot
    reg_select_slot u_slot (
      .clock (clock),
      .reset (reset),
      .set   (set_v[g]),
      .clr   (clr_v[g]),
      .q     (busy_q[g]),
      .d     (busy_d[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_sel_q  <= '0;
      wr_en_q      <= '0;
      busy_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      issue_sel_q  <= set_v;
      wr_en_q      <= clr_v;
      busy_count_q <= popcount(busy_d);
      err_q        <= err_q | wb_hit_idle;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.issue_sel   = issue_sel_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.busy        = busy_q;
  assign bus.busy_count  = busy_count_q;
  assign bus.err_wb_idle = err_q;
endmodule
